// File: rtl/imm_gen_pkg.sv
// Shared definitions for the pipelined immediate generator: RV opcodes,
// immediate format codes and a sign-extension helper.
package imm_gen_pkg;

    // Widest supported datapath; narrower builds slice the low XLEN bits.
    localparam int MAX_XLEN = 64;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_SH   = 3'd6,
        FMT_R    = 3'd7
    } imm_fmt_e;

    // Sign-extend the low src_w bits of val to MAX_XLEN bits; callers keep
    // the low XLEN bits. src_w is always a constant at the call site.
    function automatic logic [MAX_XLEN-1:0] sext(input logic [31:0] val,
                                                 input int unsigned src_w);
        logic signed [MAX_XLEN-1:0] t;
        t = $signed({{(MAX_XLEN-32){1'b0}}, val} << (MAX_XLEN - src_w));
        return t >>> (MAX_XLEN - src_w);
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decode: format classification, extension to XLEN,
// unknown-opcode flag and PC-relative target for B, J and AUIPC.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] imm_o,
    output imm_fmt_e        fmt_o,
    output logic            illegal_o,
    output logic [XLEN-1:0] target_o
);

    localparam int SHAMT_W = (XLEN == 64) ? 6 : 5;

    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic [MAX_XLEN-1:0] imm_wide;
    logic                use_target;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];

    // Opcode decode; the case key covers inst[1:0] so compressed encodings fall to default.
    always_comb begin
        imm_wide   = '0;
        fmt_o      = FMT_NONE;
        illegal_o  = 1'b0;
        use_target = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    fmt_o                  = FMT_SH;
                    imm_wide[SHAMT_W-1:0] = inst_i[20 +: SHAMT_W];
                end else begin
                    fmt_o    = FMT_I;
                    imm_wide = sext({20'b0, inst_i[31:20]}, 12);
                end
            end
            OPC_LOAD, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: begin
                fmt_o    = FMT_I;
                imm_wide = sext({20'b0, inst_i[31:20]}, 12);
            end
            OPC_STORE: begin
                fmt_o    = FMT_S;
                imm_wide = sext({20'b0, inst_i[31:25], inst_i[11:7]}, 12);
            end
            OPC_BRANCH: begin
                fmt_o      = FMT_B;
                use_target = 1'b1;
                imm_wide   = sext({19'b0, inst_i[31], inst_i[7], inst_i[30:25],
                                   inst_i[11:8], 1'b0}, 13);
            end
            OPC_LUI: begin
                fmt_o    = FMT_U;
                imm_wide = sext({inst_i[31:12], 12'b0}, 32);
            end
            OPC_AUIPC: begin
                fmt_o      = FMT_U;
                use_target = 1'b1;
                imm_wide   = sext({inst_i[31:12], 12'b0}, 32);
            end
            OPC_JAL: begin
                fmt_o      = FMT_J;
                use_target = 1'b1;
                imm_wide   = sext({11'b0, inst_i[31], inst_i[19:12], inst_i[20],
                                   inst_i[30:21], 1'b0}, 21);
            end
            OPC_OP: begin
                fmt_o = FMT_R;
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

    assign imm_o    = imm_wide[XLEN-1:0];
    assign target_o = use_target ? (pc_i + imm_o) : '0;

    // Upper bits of the wide helper result are meaningless below MAX_XLEN.
    if (XLEN < MAX_XLEN) begin : g_hi_sink
        logic unused_imm_hi;
        assign unused_imm_hi = ^imm_wide[MAX_XLEN-1:XLEN];
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator between fetch and decode/execute: a main
// output register plus one skid entry give full throughput with a
// registered in_ready.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_pc
);

    // Handshake: a beat moves on a side when its valid and ready are both
    // high at a rising clk edge. in_ready is a flop equal to "skid empty",
    // so it never depends combinationally on out_ready; out_* come straight
    // from the main register and hold while out_valid & !out_ready.

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] imm;
        imm_fmt_e        fmt;
        logic            illegal;
    } entry_t;

    entry_t          dec_entry;
    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] dec_target;
    imm_fmt_e        dec_fmt;
    logic            dec_illegal;

    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   in_ready_q, in_ready_d;
    logic   accept;
    logic   drain;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .inst_i    (in_inst),
        .pc_i      (in_pc),
        .imm_o     (dec_imm),
        .fmt_o     (dec_fmt),
        .illegal_o (dec_illegal),
        .target_o  (dec_target)
    );

    assign dec_entry = '{pc: in_pc, target: dec_target, imm: dec_imm,
                         fmt: dec_fmt, illegal: dec_illegal};

    assign accept = in_valid & in_ready_q;
    assign drain  = main_valid_q & out_ready;

    // Buffer control: flush wins, then refill main (from skid first), else park in skid.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_d       = '0;
            skid_d       = '0;
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || drain) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = dec_entry;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec_entry;
            skid_valid_d = 1'b1;
        end
        in_ready_d = !skid_valid_d;
    end

    // State registers; reset empties both entries and holds in_ready low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = main_valid_q;
    assign out_imm     = main_q.imm;
    assign out_fmt     = main_q.fmt;
    assign out_illegal = main_q.illegal;
    assign out_target  = main_q.target;
    assign out_pc      = main_q.pc;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances, decode
// vectors, backpressure through the skid entry, flush and async reset.
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic flush;

    // XLEN=32 instance
    logic        in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0] in_inst, in_pc, out_imm, out_target, out_pc;
    logic [2:0]  out_fmt;

    // XLEN=64 instance
    logic        in_valid_64, in_ready_64, out_valid_64, out_ready_64, out_illegal_64;
    logic [31:0] in_inst_64;
    logic [63:0] in_pc_64, out_imm_64, out_target_64, out_pc_64;
    logic [2:0]  out_fmt_64;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_imm_q[$];

    imm_gen_pipe #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_illegal(out_illegal), .out_target(out_target),
        .out_pc(out_pc)
    );

    imm_gen_pipe #(.XLEN(64)) dut_64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid_64), .in_ready(in_ready_64), .in_inst(in_inst_64),
        .in_pc(in_pc_64), .out_valid(out_valid_64), .out_ready(out_ready_64),
        .out_imm(out_imm_64), .out_fmt(out_fmt_64), .out_illegal(out_illegal_64),
        .out_target(out_target_64), .out_pc(out_pc_64)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send32(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                          input logic [31:0] e_imm, input logic [2:0] e_fmt,
                          input logic e_ill, input logic [31:0] e_tgt);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_inst   = inst;
        in_pc     = pc;
        check({tag, "_in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_imm"}, out_imm, e_imm);
        check({tag, "_fmt"}, out_fmt, e_fmt);
        check({tag, "_illegal"}, out_illegal, e_ill);
        check({tag, "_target"}, out_target, e_tgt);
        check({tag, "_pc"}, out_pc, pc);
        tick();
    endtask

    task automatic send64(input string tag, input logic [31:0] inst, input logic [63:0] pc,
                          input logic [63:0] e_imm, input logic [2:0] e_fmt,
                          input logic [63:0] e_tgt);
        out_ready_64 = 1'b1;
        in_valid_64  = 1'b1;
        in_inst_64   = inst;
        in_pc_64     = pc;
        tick();
        in_valid_64 = 1'b0;
        check({tag, "_valid"}, out_valid_64, 1);
        check({tag, "_imm"}, out_imm_64, e_imm);
        check({tag, "_fmt"}, out_fmt_64, e_fmt);
        check({tag, "_target"}, out_target_64, e_tgt);
        tick();
    endtask

    // Bound on total run time in case the DUT never responds.
    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nxt;
        int budget;
        logic [31:0] bp_inst[4];
        logic [31:0] bp_pc[4];

        rst = 1'b1; flush = 1'b0;
        in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
        in_valid_64 = 1'b0; in_inst_64 = '0; in_pc_64 = '0; out_ready_64 = 1'b0;

        // ---- reset state ----
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_imm", out_imm, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_in_ready_64", in_ready_64, 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        tick();
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);

        // ---- XLEN=32 decode vectors ----
        send32("addi_m1", 32'hFFF00093, 32'h0,    32'hFFFFFFFF, 3'd1, 1'b0, 32'h0);
        send32("beq_m4",  32'hFE000EE3, 32'h100,  32'hFFFFFFFC, 3'd3, 1'b0, 32'h000000FC);
        send32("jal_8",   32'h0080006F, 32'h200,  32'h00000008, 3'd5, 1'b0, 32'h00000208);
        send32("auipc",   32'h12345097, 32'h1000, 32'h12345000, 3'd4, 1'b0, 32'h12346000);
        send32("srai_1",  32'h4010D093, 32'h20,   32'h00000001, 3'd6, 1'b0, 32'h0);
        send32("custom0", 32'h0000000B, 32'h24,   32'h0,        3'd0, 1'b1, 32'h0);
        send32("lui32",   32'h800000B7, 32'h28,   32'h80000000, 3'd4, 1'b0, 32'h0);
        send32("sw_m8",   32'hFE20AC23, 32'h2C,   32'hFFFFFFF8, 3'd2, 1'b0, 32'h0);
        send32("add_r",   32'h003100B3, 32'h30,   32'h0,        3'd7, 1'b0, 32'h0);
        send32("rvc_bits",32'h00000090, 32'h34,   32'h0,        3'd0, 1'b1, 32'h0);
        send32("jalr",    32'h00008067, 32'h38,   32'h0,        3'd1, 1'b0, 32'h0);

        // ---- XLEN=64 decode vectors ----
        send64("lui64",   32'h800000B7, 64'h0,    64'hFFFFFFFF80000000, 3'd4, 64'h0);
        send64("slli63",  32'h03F09093, 64'h0,    64'd63,               3'd6, 64'h0);
        send64("auipc64", 32'hFFFFF097, 64'h1000, 64'hFFFFFFFFFFFFF000, 3'd4, 64'h0);

        // ---- backpressure through the skid entry ----
        for (int k = 0; k < 4; k++) begin
            bp_inst[k] = ((k + 1) << 20) | 32'h00000093;
            bp_pc[k]   = 32'h3000 + 4 * k;
        end
        out_ready = 1'b0;
        nxt = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            in_valid = 1'b1;
            in_inst  = bp_inst[nxt];
            in_pc    = bp_pc[nxt];
            check($sformatf("bp_in_ready_c%0d", cyc), in_ready, (cyc < 2) ? 1 : 0);
            if (in_ready) begin
                exp_q.push_back(bp_pc[nxt]);
                exp_imm_q.push_back(nxt + 1);
                nxt++;
            end
            tick();
            check($sformatf("bp_hold_valid_c%0d", cyc), out_valid, 1);
            check($sformatf("bp_hold_pc_c%0d", cyc), out_pc, 32'h3000);
            check($sformatf("bp_hold_imm_c%0d", cyc), out_imm, 1);
        end
        check("bp_accepted", nxt, 2);

        out_ready = 1'b1;
        budget = 20;
        while ((nxt < 4 || exp_q.size() > 0) && budget > 0) begin
            in_valid = (nxt < 4);
            if (nxt < 4) begin
                in_inst = bp_inst[nxt];
                in_pc   = bp_pc[nxt];
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("bp_extra_output", out_pc, 32'hFFFFFFFF);
                end else begin
                    check("bp_order_pc", out_pc, exp_q.pop_front());
                    check("bp_order_imm", out_imm, exp_imm_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(bp_pc[nxt]);
                exp_imm_q.push_back(nxt + 1);
                nxt++;
            end
            tick();
            budget--;
        end
        in_valid = 1'b0;
        check("bp_drain_left", exp_q.size(), 0);
        check("bp_all_sent", nxt, 4);
        check("bp_idle_valid", out_valid, 0);

        // ---- flush with skid full and a pending instruction ----
        out_ready = 1'b0;
        in_valid  = 1'b1; in_inst = 32'h00100093; in_pc = 32'h4000;
        tick();
        in_inst = 32'h00200093; in_pc = 32'h4004;
        tick();
        check("fl_skid_full", in_ready, 0);
        in_inst = 32'h00300093; in_pc = 32'h4008;
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_out_valid", out_valid, 0);
        check("fl_in_ready", in_ready, 1);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("fl_quiet_c%0d", c), out_valid, 0);
        end
        // instruction accepted in the flush cycle is dropped
        in_valid = 1'b1; in_inst = 32'h00400093; in_pc = 32'h400C;
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_accept_dropped", out_valid, 0);

        // ---- asynchronous reset mid-stream ----
        out_ready = 1'b0;
        in_valid  = 1'b1; in_inst = 32'h00500093; in_pc = 32'h5000;
        tick();
        in_valid = 1'b0;
        check("ar_before_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("ar_out_valid", out_valid, 0);
        check("ar_out_pc", out_pc, 0);
        check("ar_out_imm", out_imm, 0);
        check("ar_in_ready", in_ready, 0);
        #2 rst = 1'b0;
        tick();
        check("ar_release_in_ready", in_ready, 1);
        check("ar_release_valid", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
